// File: rtl/stream_merge4_pkg.sv
// Shared types and the round-robin search used by the four-port merge.
package stream_merge_pkg;
  localparam int NUM_PORTS = 4;
  localparam int PORT_AW   = 2;

  typedef logic [PORT_AW-1:0] port_idx_t;

  typedef struct packed {
    logic      valid;
    port_idx_t idx;
  } rr_grant_t;

  // Search last+1 .. last+4 (mod 4). The loop runs from farthest to nearest,
  // so the nearest requester overwrites the result and wins.
  function automatic rr_grant_t rr_next(input logic [NUM_PORTS-1:0] req,
                                        input port_idx_t last);
    rr_grant_t g;
    port_idx_t cand;
    g = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      cand = last + port_idx_t'(k);
      if (req[cand]) begin
        g.valid = 1'b1;
        g.idx   = cand;
      end
    end
    return g;
  endfunction
endpackage

// File: rtl/stream_merge4_if.sv
// Bus bundle for the four source ports and the merged, address-tagged output.
// Handshake: a word moves when en and rdy are both high at a rising clock edge.
// A source that sees rdy low holds its word; the sink may stall with rdy low.
import stream_merge_pkg::*;

interface stream_merge4_if #(parameter int DATA_WIDTH = 32);
  logic [DATA_WIDTH-1:0] din0, din1, din2, din3;
  logic                  din_en0, din_en1, din_en2, din_en3;
  logic                  din_rdy0, din_rdy1, din_rdy2, din_rdy3;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_en;
  port_idx_t             dout_addr;
  logic                  dout_rdy;

  // master: the sources and the sink around the merge
  modport master (
    output din0, din1, din2, din3, din_en0, din_en1, din_en2, din_en3, dout_rdy,
    input  din_rdy0, din_rdy1, din_rdy2, din_rdy3, dout, dout_en, dout_addr
  );

  // slave: the merge itself
  modport slave (
    input  din0, din1, din2, din3, din_en0, din_en1, din_en2, din_en3, dout_rdy,
    output din_rdy0, din_rdy1, din_rdy2, din_rdy3, dout, dout_en, dout_addr
  );
endinterface

// File: rtl/stream_merge4_rr_arbiter4.sv
// Four-way round-robin arbiter; owns last_grant, which moves only on a real grant.
import stream_merge_pkg::*;

module rr_arbiter4 (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 advance,
  output logic                 gnt_valid,
  output port_idx_t            gnt_idx
);
  port_idx_t last_grant;
  rr_grant_t gnt;

  always_comb begin
    gnt       = rr_next(req, last_grant);
    gnt_valid = gnt.valid;
    gnt_idx   = gnt.idx;
  end

  // Reset to 3 so that port 0 is searched first.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= port_idx_t'(NUM_PORTS - 1);
    end else if (advance && gnt_valid) begin
      last_grant <= gnt_idx;
    end
  end
endmodule

// File: rtl/stream_merge4.sv
// Four-to-one merge: one-entry buffer per port, round-robin grant into a
// registered output stage tagged with the source port index.
import stream_merge_pkg::*;

module stream_merge4 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  stream_merge4_if.slave  bus
);
  logic [DATA_WIDTH-1:0] din_a    [NUM_PORTS];
  logic [NUM_PORTS-1:0]  din_en_a;
  logic [DATA_WIDTH-1:0] buf_data [NUM_PORTS];
  logic [NUM_PORTS-1:0]  buf_valid;

  logic [DATA_WIDTH-1:0] dout_q;
  logic                  dout_en_q;
  port_idx_t             dout_addr_q;

  logic      load;
  logic      grant;
  logic      gnt_valid;
  port_idx_t gnt_idx;

  assign din_a[0] = bus.din0;
  assign din_a[1] = bus.din1;
  assign din_a[2] = bus.din2;
  assign din_a[3] = bus.din3;
  assign din_en_a = {bus.din_en3, bus.din_en2, bus.din_en1, bus.din_en0};

  // Ready is purely the inverse of a buffer register: no path from en/rdy inputs.
  assign bus.din_rdy0 = ~buf_valid[0];
  assign bus.din_rdy1 = ~buf_valid[1];
  assign bus.din_rdy2 = ~buf_valid[2];
  assign bus.din_rdy3 = ~buf_valid[3];

  assign bus.dout      = dout_q;
  assign bus.dout_en   = dout_en_q;
  assign bus.dout_addr = dout_addr_q;

  assign load  = ~dout_en_q | bus.dout_rdy;
  assign grant = load & gnt_valid;

  rr_arbiter4 u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (buf_valid),
    .advance   (load),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid   <= '0;
      dout_q      <= '0;
      dout_en_q   <= 1'b0;
      dout_addr_q <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        buf_data[i] <= '0;
      end
    end else begin
      // A granted buffer is full, so its ready is low and it cannot accept this edge.
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (grant && gnt_idx == port_idx_t'(i)) begin
          buf_valid[i] <= 1'b0;
        end else if (din_en_a[i] && !buf_valid[i]) begin
          buf_valid[i] <= 1'b1;
          buf_data[i]  <= din_a[i];
        end
      end

      if (grant) begin
        dout_q      <= buf_data[gnt_idx];
        dout_addr_q <= gnt_idx;
        dout_en_q   <= 1'b1;
      end else if (bus.dout_rdy) begin
        dout_en_q   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_stream_merge4.sv
// Directed bench for stream_merge4: latency, ordering, backpressure, fairness, reset.
import stream_merge_pkg::*;

module tb_stream_merge4;
  localparam int DW = 32;
  localparam int W  = DW + PORT_AW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stream_merge4_if #(.DATA_WIDTH(DW)) bus ();

  stream_merge4 #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  // Record every completed output transfer, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset && bus.dout_en && bus.dout_rdy) got_q.push_back({bus.dout_addr, bus.dout});
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_port(input int p, input logic en, input logic [DW-1:0] d);
    case (p)
      0: begin bus.din_en0 = en; bus.din0 = d; end
      1: begin bus.din_en1 = en; bus.din1 = d; end
      2: begin bus.din_en2 = en; bus.din2 = d; end
      default: begin bus.din_en3 = en; bus.din3 = d; end
    endcase
  endtask

  function automatic logic [3:0] rdy_vec();
    return {bus.din_rdy3, bus.din_rdy2, bus.din_rdy1, bus.din_rdy0};
  endfunction

  task automatic idle_inputs;
    for (int p = 0; p < 4; p++) drive_port(p, 1'b0, '0);
    bus.dout_rdy = 1'b1;
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    reset = 1'b0;
    step();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle_inputs();
    step();
    total++; if (bus.dout_en !== 1'b0) begin bad++; $display("FAIL reset_dout_en: got %b want 0", bus.dout_en); end
    total++; if (bus.dout !== '0) begin bad++; $display("FAIL reset_dout: got %h want 0", bus.dout); end
    total++; if (bus.dout_addr !== 2'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", bus.dout_addr); end
    total++; if (rdy_vec() !== 4'hF) begin bad++; $display("FAIL reset_rdy: got %b want 1111", rdy_vec()); end
    reset = 1'b0;
    step();
    step();
    total++; if (bus.dout_en !== 1'b0) begin bad++; $display("FAIL idle_dout_en: got %b want 0", bus.dout_en); end
    total++; if (rdy_vec() !== 4'hF) begin bad++; $display("FAIL idle_rdy: got %b want 1111", rdy_vec()); end
  endtask

  task automatic test_single;
    apply_reset();
    drive_port(2, 1'b1, 32'hCAFE0002);
    step();
    drive_port(2, 1'b0, '0);
    total++; if (rdy_vec() !== 4'b1011) begin bad++; $display("FAIL single_rdy_t1: got %b want 1011", rdy_vec()); end
    total++; if (bus.dout_en !== 1'b0) begin bad++; $display("FAIL single_en_t1: got %b want 0", bus.dout_en); end
    step();
    total++; if (bus.dout_en !== 1'b1) begin bad++; $display("FAIL single_en_t2: got %b want 1", bus.dout_en); end
    total++; if (bus.dout !== 32'hCAFE0002) begin bad++; $display("FAIL single_dout: got %h want cafe0002", bus.dout); end
    total++; if (bus.dout_addr !== 2'd2) begin bad++; $display("FAIL single_addr: got %0d want 2", bus.dout_addr); end
    total++; if (rdy_vec() !== 4'hF) begin bad++; $display("FAIL single_rdy_t2: got %b want 1111", rdy_vec()); end
    step();
    total++; if (bus.dout_en !== 1'b0) begin bad++; $display("FAIL single_en_t3: got %b want 0", bus.dout_en); end
    total++; if (got_q.size() !== 1) begin bad++; $display("FAIL single_count: got %0d want 1", got_q.size()); end
    else begin
      total++; if (got_q[0] !== {2'd2, 32'hCAFE0002}) begin bad++; $display("FAIL single_word: got %h want 2cafe0002", got_q[0]); end
    end
  endtask

  task automatic test_all_four;
    logic [DW-1:0] want;
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < 4; p++) drive_port(p, 1'b1, 32'hA0 + DW'(4 * r + p));
      step();
      for (int p = 0; p < 4; p++) drive_port(p, 1'b0, '0);
      total++; if (rdy_vec() !== 4'h0) begin bad++; $display("FAIL all4_full_r%0d: got %b want 0000", r, rdy_vec()); end
      for (int k = 0; k < 4; k++) begin
        step();
        want = 32'hA0 + DW'(4 * r + k);
        total++; if (bus.dout_en !== 1'b1) begin bad++; $display("FAIL all4_en_r%0d_k%0d: got %b want 1", r, k, bus.dout_en); end
        total++; if (bus.dout_addr !== port_idx_t'(k)) begin bad++; $display("FAIL all4_addr_r%0d_k%0d: got %0d want %0d", r, k, bus.dout_addr, k); end
        total++; if (bus.dout !== want) begin bad++; $display("FAIL all4_dout_r%0d_k%0d: got %h want %h", r, k, bus.dout, want); end
      end
    end
  endtask

  task automatic test_backpressure;
    apply_reset();
    bus.dout_rdy = 1'b0;
    drive_port(1, 1'b1, 32'hB1);
    step();
    drive_port(1, 1'b0, '0);
    step();
    drive_port(0, 1'b1, 32'hB0);
    drive_port(1, 1'b1, 32'hC1);
    drive_port(2, 1'b1, 32'hB2);
    drive_port(3, 1'b1, 32'hB3);
    step();
    for (int p = 0; p < 4; p++) drive_port(p, 1'b0, '0);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) drive_port(0, 1'b1, 32'hDEAD);
      if (c == 3) drive_port(0, 1'b0, '0);
      total++; if (bus.dout_en !== 1'b1) begin bad++; $display("FAIL bp_en_c%0d: got %b want 1", c, bus.dout_en); end
      total++; if (bus.dout !== 32'hB1) begin bad++; $display("FAIL bp_dout_c%0d: got %h want b1", c, bus.dout); end
      total++; if (bus.dout_addr !== 2'd1) begin bad++; $display("FAIL bp_addr_c%0d: got %0d want 1", c, bus.dout_addr); end
      total++; if (rdy_vec() !== 4'h0) begin bad++; $display("FAIL bp_rdy_c%0d: got %b want 0000", c, rdy_vec()); end
      step();
    end
    bus.dout_rdy = 1'b1;
    for (int c = 0; c < 8; c++) step();
    exp_q.push_back({2'd1, 32'hB1});
    exp_q.push_back({2'd2, 32'hB2});
    exp_q.push_back({2'd3, 32'hB3});
    exp_q.push_back({2'd0, 32'hB0});
    exp_q.push_back({2'd1, 32'hC1});
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL bp_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    total++; if (rdy_vec() !== 4'hF) begin bad++; $display("FAIL bp_rdy_after: got %b want 1111", rdy_vec()); end
  endtask

  task automatic test_fairness;
    int n0;
    int pos3;
    logic acc0, acc3;
    logic [DW-1:0] next0;
    apply_reset();
    n0 = 0;
    next0 = 32'h100;
    drive_port(0, 1'b1, next0);
    drive_port(3, 1'b1, 32'h333);
    for (int c = 0; c < 12; c++) begin
      acc0 = bus.din_en0 && bus.din_rdy0;
      acc3 = bus.din_en3 && bus.din_rdy3;
      step();
      if (acc0) begin n0++; next0 = next0 + 1; drive_port(0, 1'b1, next0); end
      if (acc3) drive_port(3, 1'b0, '0);
    end
    drive_port(0, 1'b0, '0);
    for (int c = 0; c < 4; c++) step();
    pos3 = -1;
    for (int i = 0; i < got_q.size(); i++) if (got_q[i][W-1 -: 2] == 2'd3) pos3 = i;
    total++; if (pos3 < 0 || pos3 > 1) begin bad++; $display("FAIL fair_pos3: got %0d want 0 or 1", pos3); end
    total++; if (got_q.size() !== n0 + 1) begin bad++; $display("FAIL fair_count: got %0d want %0d", got_q.size(), n0 + 1); end
    for (int i = 0; i < n0 + 1; i++) exp_q.push_back('0);
    exp_q.delete();
    for (int i = 0; i < n0; i++) exp_q.push_back({2'd0, 32'h100 + DW'(i)});
    begin
      int j;
      j = 0;
      for (int i = 0; i < got_q.size(); i++) begin
        if (got_q[i][W-1 -: 2] == 2'd0 && j < exp_q.size()) begin
          total++; if (got_q[i] !== exp_q[j]) begin bad++; $display("FAIL fair_p0_word%0d: got %h want %h", j, got_q[i], exp_q[j]); end
          j++;
        end
      end
      total++; if (j !== n0) begin bad++; $display("FAIL fair_p0_count: got %0d want %0d", j, n0); end
    end
  endtask

  task automatic test_reset_mid;
    apply_reset();
    bus.dout_rdy = 1'b0;
    drive_port(2, 1'b1, 32'hE2);
    step();
    drive_port(2, 1'b0, '0);
    step();
    drive_port(0, 1'b1, 32'hE0);
    drive_port(1, 1'b1, 32'hE1);
    step();
    drive_port(0, 1'b0, '0);
    drive_port(1, 1'b0, '0);
    total++; if (bus.dout_en !== 1'b1) begin bad++; $display("FAIL mid_en_before: got %b want 1", bus.dout_en); end
    total++; if (rdy_vec() !== 4'b1100) begin bad++; $display("FAIL mid_rdy_before: got %b want 1100", rdy_vec()); end
    reset = 1'b1;
    step();
    total++; if (bus.dout_en !== 1'b0) begin bad++; $display("FAIL mid_en_reset: got %b want 0", bus.dout_en); end
    total++; if (rdy_vec() !== 4'hF) begin bad++; $display("FAIL mid_rdy_reset: got %b want 1111", rdy_vec()); end
    total++; if (bus.dout !== '0) begin bad++; $display("FAIL mid_dout_reset: got %h want 0", bus.dout); end
    reset = 1'b0;
    bus.dout_rdy = 1'b1;
    for (int c = 0; c < 5; c++) step();
    total++; if (got_q.size() !== 0) begin bad++; $display("FAIL mid_leak: got %0d words want 0", got_q.size()); end
    total++; if (bus.dout_en !== 1'b0) begin bad++; $display("FAIL mid_en_after: got %b want 0", bus.dout_en); end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_all_four();
    test_backpressure();
    test_fairness();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
